// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit and its datapath.
// Holds the opcode and funct encodings, the 4-bit ALU function codes (also
// used by the ALU), the controller state enum, and the mux-select encodings
// for alu_src_b and pc_src.
package mips_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_LUI = 4'b1110;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ORIEX  = 4'd10,
        LUIEX  = 4'd11,
        IMMWB  = 4'd12,
        JUMP   = 4'd13
    } state_t;

    // ALU In2 select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the control unit and the shared multicycle datapath.
//   master : control unit   (takes op/funct/zero, drives selects and strobes)
//   slave  : datapath side  (drives op/funct/zero, takes selects and strobes)
interface mips_multicycle_control_if;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_src;
    logic [3:0] alu_func;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, imm_zext, pc_src,
               alu_func, illegal, state
    );

    modport slave (
        output op, funct, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, imm_zext, pc_src,
               alu_func, illegal, state
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational R-type decoder: maps the funct field to an ALU function code
// and flags encodings the ALU does not implement.
//   funct     in  6  instruction[5:0]
//   alu_func  out 4  ALU function code (ADD when funct is unknown)
//   bad_funct out 1  funct is not a supported R-type operation
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_func,
    output logic       bad_funct
);

    always_comb begin
        alu_func  = ALU_ADD;
        bad_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_func = ALU_ADD;
            FN_SUB:  alu_func = ALU_SUB;
            FN_AND:  alu_func = ALU_AND;
            FN_OR:   alu_func = ALU_OR;
            FN_XOR:  alu_func = ALU_XOR;
            FN_SLT:  alu_func = ALU_SLT;
            default: bad_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM. Steps each instruction through fetch, decode,
// execute, memory and writeback and drives the datapath selects, write
// strobes and ALU function code from the current state.
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-high; forces FETCH and kills all strobes
//   ctl    master side of mips_multicycle_control_if (op/funct/zero in,
//          selects, strobes, alu_func, illegal and debug state out)
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC + 4
// DECODE | read registers, branch target into ALUOut, dispatch on op
// MEMADR | lw/sw effective address = A + sign-extended imm
// MEMRD  | read data memory at ALUOut
// MEMWB  | write MDR to rt
// MEMWR  | write B to memory at ALUOut
// RTEX   | R-type ALU operation A op B
// ALUWB  | write ALUOut to rd
// BEQ    | compare A - B, load PC from ALUOut when equal
// ADDIEX | A + sign-extended imm
// ORIEX  | A | zero-extended imm
// LUIEX  | imm << 16
// IMMWB  | write ALUOut to rt
// JUMP   | load PC with jump target
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master  ctl
);

    state_t     state_q, state_d;
    logic [3:0] rfunc_q, rfunc_d;
    logic       is_lw_q, is_lw_d;

    logic [3:0] dec_func;
    logic       bad_funct;
    logic       decode_illegal;

    alu_decoder u_alu_decoder (
        .funct     (ctl.funct),
        .alu_func  (dec_func),
        .bad_funct (bad_funct)
    );

    // Next state. The R-type function code and the lw/sw choice are captured
    // in DECODE so later IR changes cannot redirect the instruction.
    always_comb begin
        state_d        = state_q;
        rfunc_d        = rfunc_q;
        is_lw_d        = is_lw_q;
        decode_illegal = 1'b0;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                is_lw_d = (ctl.op == OP_LW);
                case (ctl.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE: begin
                        if (bad_funct) begin
                            state_d        = FETCH;
                            decode_illegal = 1'b1;
                        end else begin
                            state_d = RTEX;
                            rfunc_d = dec_func;
                        end
                    end
                    OP_BEQ:  state_d = BEQ;
                    OP_ADDI: state_d = ADDIEX;
                    OP_ORI:  state_d = ORIEX;
                    OP_LUI:  state_d = LUIEX;
                    OP_J:    state_d = JUMP;
                    default: begin
                        state_d        = FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = is_lw_q ? MEMRD : MEMWR;
            MEMRD:  state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = FETCH;
            RTEX:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BEQ:    state_d = FETCH;
            ADDIEX: state_d = IMMWB;
            ORIEX:  state_d = IMMWB;
            LUIEX:  state_d = IMMWB;
            IMMWB:  state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            rfunc_q <= ALU_ADD;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rfunc_q <= rfunc_d;
            is_lw_q <= is_lw_d;
        end
    end

    // Moore output decode. Strobes are gated by reset so an aborted
    // instruction can never complete a write while reset is applied.
    logic pc_en_s, mem_write_s, ir_write_s, reg_write_s;

    always_comb begin
        pc_en_s        = 1'b0;
        mem_write_s    = 1'b0;
        ir_write_s     = 1'b0;
        reg_write_s    = 1'b0;
        ctl.iord       = 1'b0;
        ctl.reg_dst    = 1'b0;
        ctl.mem_to_reg = 1'b0;
        ctl.alu_src_a  = 1'b0;
        ctl.alu_src_b  = SRCB_REG;
        ctl.imm_zext   = 1'b0;
        ctl.pc_src     = PCSRC_ALU;
        ctl.alu_func   = ALU_ADD;
        case (state_q)
            FETCH: begin
                ir_write_s    = 1'b1;
                pc_en_s       = 1'b1;
                ctl.alu_src_b = SRCB_FOUR;
            end
            DECODE: ctl.alu_src_b = SRCB_BRANCH;
            MEMADR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            MEMRD: ctl.iord = 1'b1;
            MEMWB: begin
                reg_write_s    = 1'b1;
                ctl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctl.iord    = 1'b1;
                mem_write_s = 1'b1;
            end
            RTEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_func  = rfunc_q;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                ctl.reg_dst = 1'b1;
            end
            BEQ: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_func  = ALU_SUB;
                ctl.pc_src    = PCSRC_ALUOUT;
                pc_en_s       = ctl.zero;
            end
            ADDIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            ORIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.imm_zext  = 1'b1;
                ctl.alu_func  = ALU_OR;
            end
            LUIEX: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_func  = ALU_LUI;
            end
            IMMWB: reg_write_s = 1'b1;
            JUMP: begin
                ctl.pc_src = PCSRC_JUMP;
                pc_en_s    = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctl.pc_en     = pc_en_s & ~reset;
    assign ctl.mem_write = mem_write_s & ~reset;
    assign ctl.ir_write  = ir_write_s & ~reset;
    assign ctl.reg_write = reg_write_s & ~reset;
    assign ctl.illegal   = decode_illegal & ~reset;
    assign ctl.state     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;
    import mips_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_src;
        logic [3:0] alu_func;
        logic       illegal;
    } vec_t;

    typedef struct packed {
        vec_t exp;
        vec_t msk;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    int   n_asserts = 0;
    int   n_fails   = 0;
    entry_t sb[$];

    always #5 clk = ~clk;

    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    function automatic vec_t observe();
        vec_t v;
        v.st         = bus.state;
        v.pc_en      = bus.pc_en;
        v.iord       = bus.iord;
        v.mem_write  = bus.mem_write;
        v.ir_write   = bus.ir_write;
        v.reg_dst    = bus.reg_dst;
        v.mem_to_reg = bus.mem_to_reg;
        v.reg_write  = bus.reg_write;
        v.alu_src_a  = bus.alu_src_a;
        v.alu_src_b  = bus.alu_src_b;
        v.imm_zext   = bus.imm_zext;
        v.pc_src     = bus.pc_src;
        v.alu_func   = bus.alu_func;
        v.illegal    = bus.illegal;
        return v;
    endfunction

    // Expected outputs for one state; only the fields the state defines are masked in.
    function automatic entry_t model(state_t st, logic [3:0] rf, logic z, logic ill);
        entry_t e;
        e.exp = '0;
        e.msk = '0;
        e.exp.st = st;
        e.msk.st = 4'hF;
        e.msk.pc_en = 1'b1;
        e.msk.mem_write = 1'b1;
        e.msk.ir_write = 1'b1;
        e.msk.reg_write = 1'b1;
        e.msk.illegal = 1'b1;
        e.exp.illegal = ill;
        case (st)
            FETCH: begin
                e.exp.ir_write = 1'b1; e.exp.pc_en = 1'b1;
                e.exp.alu_src_b = 2'b01; e.exp.alu_func = 4'b0010;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11;
                e.msk.alu_func = 4'hF; e.msk.pc_src = 2'b11;
            end
            DECODE: begin
                e.exp.alu_src_b = 2'b11; e.exp.alu_func = 4'b0010;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11; e.msk.alu_func = 4'hF;
            end
            MEMADR: begin
                e.exp.alu_src_a = 1'b1; e.exp.alu_src_b = 2'b10; e.exp.alu_func = 4'b0010;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11; e.msk.alu_func = 4'hF;
            end
            MEMRD: begin
                e.exp.iord = 1'b1; e.msk.iord = 1'b1;
            end
            MEMWB: begin
                e.exp.reg_write = 1'b1; e.exp.mem_to_reg = 1'b1;
                e.msk.mem_to_reg = 1'b1; e.msk.reg_dst = 1'b1;
            end
            MEMWR: begin
                e.exp.iord = 1'b1; e.exp.mem_write = 1'b1; e.msk.iord = 1'b1;
            end
            RTEX: begin
                e.exp.alu_src_a = 1'b1; e.exp.alu_func = rf;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11; e.msk.alu_func = 4'hF;
            end
            ALUWB: begin
                e.exp.reg_write = 1'b1; e.exp.reg_dst = 1'b1; e.msk.reg_dst = 1'b1;
            end
            BEQ: begin
                e.exp.alu_src_a = 1'b1; e.exp.alu_func = 4'b0110;
                e.exp.pc_src = 2'b01; e.exp.pc_en = z;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11;
                e.msk.alu_func = 4'hF; e.msk.pc_src = 2'b11;
            end
            ADDIEX, ORIEX, LUIEX: begin
                e.exp.alu_src_a = 1'b1; e.exp.alu_src_b = 2'b10;
                e.msk.alu_src_a = 1'b1; e.msk.alu_src_b = 2'b11; e.msk.alu_func = 4'hF;
                if (st == ADDIEX) e.exp.alu_func = 4'b0010;
                if (st == LUIEX)  e.exp.alu_func = 4'b1110;
                if (st == ORIEX) begin
                    e.exp.alu_func = 4'b0001;
                    e.exp.imm_zext = 1'b1;
                    e.msk.imm_zext = 1'b1;
                end
            end
            IMMWB: begin
                e.exp.reg_write = 1'b1; e.msk.reg_dst = 1'b1;
            end
            JUMP: begin
                e.exp.pc_src = 2'b10; e.exp.pc_en = 1'b1; e.msk.pc_src = 2'b11;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic entry_t reset_entry();
        entry_t e;
        e.exp = '0;
        e.exp.st = FETCH;
        e.exp.alu_src_b = 2'b01;
        e.exp.alu_func = 4'b0010;
        e.msk = '1;
        e.msk.iord = 1'b0;
        e.msk.reg_dst = 1'b0;
        e.msk.mem_to_reg = 1'b0;
        e.msk.imm_zext = 1'b0;
        return e;
    endfunction

    task automatic check(string tag, int cyc, vec_t obs, entry_t e);
        n_asserts++;
        assert ((obs & e.msk) === (e.exp & e.msk)) else begin
            n_fails++;
            $error("FAIL %s cyc%0d observed=%h expected=%h mask=%h",
                   tag, cyc, obs & e.msk, e.exp & e.msk, e.msk);
        end
    endtask

    // Pushes the expected per-cycle outputs of one instruction.
    task automatic push_instr(logic [5:0] op, logic [5:0] fn, logic z);
        logic [3:0] rf;
        logic       ok;
        ok = 1'b1;
        rf = 4'b0010;
        case (fn)
            6'b100000: rf = 4'b0010;
            6'b100010: rf = 4'b0110;
            6'b100100: rf = 4'b0000;
            6'b100101: rf = 4'b0001;
            6'b100110: rf = 4'b1000;
            6'b101010: rf = 4'b0111;
            default:   ok = 1'b0;
        endcase
        sb.push_back(model(FETCH, rf, z, 1'b0));
        case (op)
            6'b100011: begin
                sb.push_back(model(DECODE, rf, z, 1'b0));
                sb.push_back(model(MEMADR, rf, z, 1'b0));
                sb.push_back(model(MEMRD, rf, z, 1'b0));
                sb.push_back(model(MEMWB, rf, z, 1'b0));
            end
            6'b101011: begin
                sb.push_back(model(DECODE, rf, z, 1'b0));
                sb.push_back(model(MEMADR, rf, z, 1'b0));
                sb.push_back(model(MEMWR, rf, z, 1'b0));
            end
            6'b000000: begin
                sb.push_back(model(DECODE, rf, z, !ok));
                if (ok) begin
                    sb.push_back(model(RTEX, rf, z, 1'b0));
                    sb.push_back(model(ALUWB, rf, z, 1'b0));
                end
            end
            6'b000100: begin
                sb.push_back(model(DECODE, rf, z, 1'b0));
                sb.push_back(model(BEQ, rf, z, 1'b0));
            end
            6'b001000, 6'b001101, 6'b001111: begin
                sb.push_back(model(DECODE, rf, z, 1'b0));
                if (op == 6'b001000) sb.push_back(model(ADDIEX, rf, z, 1'b0));
                if (op == 6'b001101) sb.push_back(model(ORIEX, rf, z, 1'b0));
                if (op == 6'b001111) sb.push_back(model(LUIEX, rf, z, 1'b0));
                sb.push_back(model(IMMWB, rf, z, 1'b0));
            end
            6'b000010: begin
                sb.push_back(model(DECODE, rf, z, 1'b0));
                sb.push_back(model(JUMP, rf, z, 1'b0));
            end
            default: sb.push_back(model(DECODE, rf, z, 1'b1));
        endcase
    endtask

    // Drives one instruction and compares every cycle; ncyc truncates the run.
    // scramble alters funct after DECODE to prove the R-type code is latched.
    task automatic run_instr(string tag, logic [5:0] op, logic [5:0] fn, logic z,
                             int ncyc, bit scramble);
        entry_t e;
        bus.op = op;
        bus.funct = fn;
        bus.zero = z;
        push_instr(op, fn, z);
        for (int c = 0; c < ncyc && sb.size() > 0; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            check(tag, c, observe(), e);
            @(posedge clk);
            #1;
            if (scramble && c == 1) bus.funct = 6'b100100;
        end
        sb.delete();
    endtask

    initial begin
        reset = 1'b1;
        bus.op = 6'b0;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        #12;
        check("reset_hold", 0, observe(), reset_entry());
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw",      6'b100011, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("sub",     6'b000000, 6'b100010, 1'b0, 99, 1'b1);
        run_instr("slt",     6'b000000, 6'b101010, 1'b0, 99, 1'b0);
        run_instr("beq_t",   6'b000100, 6'b000000, 1'b1, 99, 1'b0);
        run_instr("beq_nt",  6'b000100, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("addi",    6'b001000, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("ori",     6'b001101, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("lui",     6'b001111, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("j",       6'b000010, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("sw",      6'b101011, 6'b000000, 1'b0, 99, 1'b0);
        run_instr("bad_op",  6'b111111, 6'b100000, 1'b0, 99, 1'b0);
        run_instr("bad_fn",  6'b000000, 6'b000111, 1'b0, 99, 1'b0);
        run_instr("and",     6'b000000, 6'b100100, 1'b0, 99, 1'b0);
        run_instr("xor",     6'b000000, 6'b100110, 1'b0, 99, 1'b0);

        // Abort a store in MEMWR with an asynchronous reset.
        run_instr("sw_part", 6'b101011, 6'b000000, 1'b0, 3, 1'b0);
        @(negedge clk);
        check("memwr", 0, observe(), model(MEMWR, 4'b0010, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 0, observe(), reset_entry());
        @(posedge clk);
        #1;
        check("reset_held", 0, observe(), reset_entry());
        reset = 1'b0;
        run_instr("lw_post", 6'b100011, 6'b000000, 1'b0, 99, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
